// File: rtl/bus_cycle_ctrl.sv
// 8085 machine-cycle sequencer: drives T1/T2/TW/T3..T6, wait states, HOLD/HLDA and HALT.
// Optional wait-state timeout is compiled in with `define WAIT_TIMEOUT_EN.
module bus_cycle_ctrl #(
  parameter int unsigned MAX_WAIT   = 15,
  parameter int unsigned WAIT_CNT_W = 4
) (
  input  logic        phi1,
  input  logic        reset,
  input  logic        cyc_req,
  input  logic [2:0]  cyc_type,
  input  logic        cyc_long,
  input  logic [15:0] cyc_addr,
  input  logic [7:0]  cyc_wdata,
  input  logic [7:0]  ad_in,
  input  logic        ready,
  input  logic        hold,
  input  logic        wake,
  output logic        cyc_ack,
  output logic        cyc_done,
  output logic [7:0]  cyc_rdata,
  output logic        bus_err,
  output logic        ALE,
  output logic        RDn,
  output logic        WRn,
  output logic        IOMn,
  output logic        S1,
  output logic        S0,
  output logic [7:0]  ad_out,
  output logic [7:0]  a_hi,
  output logic        ad_oe,
  output logic        bus_oe,
  output logic        hlda,
  output logic        halted
);

  localparam logic [2:0] TyFetch = 3'd0;
  localparam logic [2:0] TyMemRd = 3'd1;
  localparam logic [2:0] TyMemWr = 3'd2;
  localparam logic [2:0] TyIoRd  = 3'd3;
  localparam logic [2:0] TyIoWr  = 3'd4;
  localparam logic [2:0] TyHalt  = 3'd5;

  if ((2 ** WAIT_CNT_W) <= MAX_WAIT) begin : g_bad_param
    $error("WAIT_CNT_W too narrow to count MAX_WAIT");
  end

  typedef enum logic [3:0] {
    StIdle, StT1, StT2, StTw, StT3, StT4, StT5, StT6, StHalt, StHold
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] type_q, type_d;
  logic       long_q, long_d;
  logic [7:0] wdata_q, wdata_d;
  logic       from_halt_q, from_halt_d;
  logic       is_final, timeout, done_d;
  logic       rd_d, wr_d, rd_q, in_cyc_d, strobe_d;
  logic [7:0] ad_out_d, a_hi_d;

`ifdef WAIT_TIMEOUT_EN
  logic [WAIT_CNT_W-1:0] wcnt_q, wcnt_d;
  logic                  err_q;

  assign timeout = (wcnt_q == WAIT_CNT_W'(MAX_WAIT));
  assign bus_err = err_q;

  always_comb begin
    wcnt_d = wcnt_q;
    if (state_d == StT1) begin
      wcnt_d = '0;
    end else if (state_d == StTw) begin
      wcnt_d = wcnt_q + WAIT_CNT_W'(1);
    end
  end

  always_ff @(posedge phi1 or posedge reset) begin
    if (reset) begin
      wcnt_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wcnt_q <= wcnt_d;
      if ((state_q == StT2 || state_q == StTw) && !ready && timeout) begin
        err_q <= 1'b1;
      end
    end
  end
`else
  assign timeout = 1'b0;
  assign bus_err = 1'b0;
`endif

  // Next state; attributes of a cycle are latched only on the edge that enters T1.
  always_comb begin
    state_d     = state_q;
    type_d      = type_q;
    long_d      = long_q;
    wdata_d     = wdata_q;
    from_halt_d = from_halt_q;
    done_d      = 1'b0;
    is_final    = (state_q == StT3 && type_q != TyFetch) ||
                  (state_q == StT4 && !long_q) || (state_q == StT6);
    if (state_q == StIdle || is_final) begin
      done_d = is_final;
      if (hold) begin
        state_d     = StHold;
        from_halt_d = 1'b0;
      end else if (cyc_req && cyc_type <= TyHalt) begin
        state_d = StT1;
        type_d  = cyc_type;
        long_d  = cyc_long;
        wdata_d = cyc_wdata;
      end else begin
        state_d = StIdle;
      end
    end else begin
      case (state_q)
        StT1:       state_d = (type_q == TyHalt) ? StHalt : StT2;
        StT2, StTw: state_d = (ready || timeout) ? StT3 : StTw;
        StT3:       state_d = StT4;
        StT4:       state_d = StT5;
        StT5:       state_d = StT6;
        StHalt: begin
          if (hold) begin
            state_d     = StHold;
            from_halt_d = 1'b1;
          end else if (wake) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
        StHold:     if (!hold) state_d = from_halt_q ? StHalt : StIdle;
        default:    state_d = StIdle;
      endcase
    end
  end

  // Pin values for the state being entered, so every output comes straight from a flop.
  always_comb begin
    rd_d     = type_d inside {TyFetch, TyMemRd, TyIoRd};
    wr_d     = type_d inside {TyMemWr, TyIoWr};
    rd_q     = type_q inside {TyFetch, TyMemRd, TyIoRd};
    in_cyc_d = state_d inside {StT1, StT2, StTw, StT3, StT4, StT5, StT6};
    strobe_d = state_d inside {StT2, StTw, StT3};
    ad_out_d = ad_out;
    a_hi_d   = a_hi;
    if (state_d == StT1) begin
      ad_out_d = cyc_addr[7:0];
      a_hi_d   = cyc_addr[15:8];
    end else if (strobe_d && wr_d) begin
      ad_out_d = wdata_d;
    end
  end

  always_ff @(posedge phi1 or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      type_q      <= '0;
      long_q      <= 1'b0;
      wdata_q     <= '0;
      from_halt_q <= 1'b0;
      cyc_ack     <= 1'b0;
      cyc_done    <= 1'b0;
      cyc_rdata   <= '0;
      ALE         <= 1'b0;
      RDn         <= 1'b1;
      WRn         <= 1'b1;
      IOMn        <= 1'b0;
      S1          <= 1'b0;
      S0          <= 1'b0;
      ad_out      <= '0;
      a_hi        <= '0;
      ad_oe       <= 1'b0;
      bus_oe      <= 1'b1;
      hlda        <= 1'b0;
      halted      <= 1'b0;
    end else begin
      state_q     <= state_d;
      type_q      <= type_d;
      long_q      <= long_d;
      wdata_q     <= wdata_d;
      from_halt_q <= from_halt_d;
      cyc_ack     <= (state_d == StT1);
      cyc_done    <= done_d;
      ALE         <= (state_d == StT1);
      RDn         <= !(strobe_d && rd_d);
      WRn         <= !(strobe_d && wr_d);
      IOMn        <= in_cyc_d && (type_d == TyIoRd || type_d == TyIoWr);
      S1          <= in_cyc_d && (type_d inside {TyFetch, TyMemRd, TyIoRd});
      S0          <= in_cyc_d && (type_d inside {TyFetch, TyMemWr, TyIoWr});
      ad_out      <= ad_out_d;
      a_hi        <= a_hi_d;
      ad_oe       <= (state_d == StT1) || (strobe_d && wr_d);
      bus_oe      <= (state_d != StHold);
      hlda        <= (state_d == StHold);
      halted      <= (state_d == StHalt);
      if (state_q == StT3 && rd_q) begin
        cyc_rdata <= ad_in;
      end
    end
  end

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// Randomized bench for bus_cycle_ctrl against a T-number based bus model, plus directed scenarios.
module tb_bus_cycle_ctrl;

  localparam int unsigned MaxW = 3;
`ifdef WAIT_TIMEOUT_EN
  localparam bit TimeoutEn = 1'b1;
`else
  localparam bit TimeoutEn = 1'b0;
`endif
  localparam logic [12:0] ResetCtrl = 13'b0_1_1_0_0_0_0_1_0_0_0_0_0;

  logic        phi1 = 1'b0;
  logic        reset = 1'b1;
  logic        cyc_req = 1'b0;
  logic [2:0]  cyc_type = '0;
  logic        cyc_long = 1'b0;
  logic [15:0] cyc_addr = '0;
  logic [7:0]  cyc_wdata = '0;
  logic [7:0]  ad_in = '0;
  logic        ready = 1'b1;
  logic        hold = 1'b0;
  logic        wake = 1'b0;
  logic        cyc_ack, cyc_done, bus_err, ALE, RDn, WRn, IOMn, S1, S0;
  logic        ad_oe, bus_oe, hlda, halted;
  logic [7:0]  cyc_rdata, ad_out, a_hi;

  int vectors = 0;
  int miscompares = 0;

  bus_cycle_ctrl #(.MAX_WAIT(MaxW), .WAIT_CNT_W(4)) dut (
    .phi1(phi1), .reset(reset), .cyc_req(cyc_req), .cyc_type(cyc_type), .cyc_long(cyc_long),
    .cyc_addr(cyc_addr), .cyc_wdata(cyc_wdata), .ad_in(ad_in), .ready(ready), .hold(hold),
    .wake(wake), .cyc_ack(cyc_ack), .cyc_done(cyc_done), .cyc_rdata(cyc_rdata),
    .bus_err(bus_err), .ALE(ALE), .RDn(RDn), .WRn(WRn), .IOMn(IOMn), .S1(S1), .S0(S0),
    .ad_out(ad_out), .a_hi(a_hi), .ad_oe(ad_oe), .bus_oe(bus_oe), .hlda(hlda), .halted(halted)
  );

  always #5 phi1 = ~phi1;

  function automatic logic [12:0] ctrl_vec();
    return {ALE, RDn, WRn, IOMn, S1, S0, ad_oe, bus_oe, hlda, halted, cyc_ack, cyc_done, bus_err};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge phi1);
  endtask

  // Model: m_t is the T-number of the cycle on the bus (0 = none); TW is T2 with m_waits > 0.
  int         m_t, m_type, m_waits;
  bit         m_halt, m_hold, m_hfrom, m_done, m_err, m_long;
  logic [7:0] m_wdata, m_alo, m_ahi, m_rdata;

  function automatic bit is_rd(int t);
    return t == 0 || t == 1 || t == 3;
  endfunction

  function automatic bit is_wr(int t);
    return t == 2 || t == 4;
  endfunction

  // {S1, S0, IOMn} per cycle type
  function automatic logic [2:0] status(int t);
    case (t)
      0:       return 3'b110;
      1:       return 3'b100;
      2:       return 3'b010;
      3:       return 3'b101;
      4:       return 3'b011;
      default: return 3'b000;
    endcase
  endfunction

  always @(posedge phi1 or posedge reset) begin
    if (reset) begin
      m_t = 0; m_type = 0; m_waits = 0; m_halt = 0; m_hold = 0; m_hfrom = 0;
      m_done = 0; m_err = 0; m_long = 0; m_wdata = '0; m_alo = '0; m_ahi = '0; m_rdata = '0;
    end else begin
      bit fin, nd;
      fin = (m_t == ((m_type == 0) ? (m_long ? 6 : 4) : 3));
      nd  = 0;
      if (m_t == 3 && is_rd(m_type)) m_rdata = ad_in;
      if (m_hold) begin
        if (!hold) begin
          m_hold = 0;
          m_halt = m_hfrom;
        end
      end else if (m_halt) begin
        if (hold) begin
          m_hold = 1; m_hfrom = 1; m_halt = 0;
        end else if (wake) begin
          m_halt = 0; nd = 1;
        end
      end else if (m_t == 0 || fin) begin
        nd = fin;
        if (hold) begin
          m_hold = 1; m_hfrom = 0; m_t = 0;
        end else if (cyc_req && cyc_type <= 3'd5) begin
          m_t = 1; m_type = int'(cyc_type); m_long = cyc_long; m_wdata = cyc_wdata;
          m_alo = cyc_addr[7:0]; m_ahi = cyc_addr[15:8]; m_waits = 0;
        end else begin
          m_t = 0;
        end
      end else if (m_t == 1) begin
        if (m_type == 5) begin
          m_t = 0; m_halt = 1;
        end else begin
          m_t = 2;
        end
      end else if (m_t == 2) begin
        if (ready) begin
          m_t = 3;
        end else if (TimeoutEn && m_waits == int'(MaxW)) begin
          m_t = 3; m_err = 1;
        end else begin
          m_waits++;
        end
      end else begin
        m_t++;
      end
      m_done = nd;
    end
  end

  always @(negedge phi1) begin
    if (!reset) begin
      logic [12:0] exp;
      logic [2:0]  st;
      bit          cyc, strb, rd, wr, oe;
      cyc  = (m_t != 0);
      strb = (m_t == 2 || m_t == 3);
      rd   = cyc && is_rd(m_type);
      wr   = cyc && is_wr(m_type);
      st   = cyc ? status(m_type) : 3'b000;
      oe   = (m_t == 1) || (strb && wr);
      exp  = {m_t == 1, !(strb && rd), !(strb && wr), st[0], st[2], st[1], oe,
              !m_hold, m_hold, m_halt, m_t == 1, m_done, m_err};
      chk("ctrl", ctrl_vec(), exp);
      chk("a_hi", a_hi, m_ahi);
      chk("cyc_rdata", cyc_rdata, m_rdata);
      if (oe) chk("ad_out", ad_out, (m_t == 1) ? m_alo : m_wdata);
    end
  end

  task automatic start(input logic [2:0] t, input logic [15:0] a, input logic [7:0] wd);
    cyc_req = 1'b1; cyc_type = t; cyc_addr = a; cyc_wdata = wd;
  endtask

  initial begin
    int n;
    bit seen;
    tick();
    chk("reset_ctrl", ctrl_vec(), ResetCtrl);
    chk("reset_rdata", cyc_rdata, 8'h00);
    #2 reset = 1'b0;

    // Mem read 2050, ready high, ad_in A5
    tick();
    start(3'd1, 16'h2050, 8'h00); ad_in = 8'hA5; ready = 1'b1;
    tick();
    chk("rd_t1_ale", {ALE, cyc_ack, S1, S0, IOMn}, 5'b11100);
    chk("rd_t1_ahi", a_hi, 8'h20);
    chk("rd_t1_adout", ad_out, 8'h50);
    cyc_req = 1'b0;
    tick();
    chk("rd_t2_rdn", {ALE, RDn, ad_oe}, 3'b000);
    tick();
    chk("rd_t3_rdn", {RDn, cyc_done}, 2'b00);
    tick();
    chk("rd_done", {cyc_done, RDn}, 2'b11);
    chk("rd_data", cyc_rdata, 8'hA5);

    // IO write 3C with two wait states
    start(3'd4, 16'h1234, 8'h3C); ready = 1'b0;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (!WRn) n++;
      if (i == 0) cyc_req = 1'b0;
      if (i == 1) begin
        chk("wr_t2_ad", ad_out, 8'h3C);
        chk("wr_t2_st", {WRn, ad_oe, IOMn, S1, S0}, 5'b01101);
      end
      if (i == 3) ready = 1'b1;
    end
    chk("wr_low_cycles", n, 4);

    // Long fetch with a second request already waiting
    start(3'd0, 16'h0100, 8'h00); cyc_long = 1'b1;
    tick();
    chk("fetch_t1", {cyc_ack, S1, S0}, 3'b111);
    for (int i = 0; i < 5; i++) tick();
    chk("fetch_t6", {cyc_ack, cyc_done}, 2'b00);
    tick();
    chk("fetch_b2b", {cyc_ack, cyc_done, ALE}, 3'b111);
    cyc_req = 1'b0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      seen = cyc_done;
    end
    chk("fetch2_done_seen", seen, 1'b1);
    cyc_long = 1'b0;

    // hold raised in T2 of a mem read
    start(3'd1, 16'h4000, 8'h00);
    tick();
    cyc_req = 1'b0; hold = 1'b1;
    tick();
    tick();
    tick();
    chk("hold_enter", {hlda, bus_oe, cyc_done}, 3'b101);
    hold = 1'b0;
    tick();
    chk("hold_exit", {hlda, bus_oe, cyc_ack, halted}, 4'b0100);

    // Halt then wake
    start(3'd5, 16'h0000, 8'h00);
    tick();
    chk("halt_t1", cyc_ack, 1'b1);
    cyc_req = 1'b0;
    tick();
    chk("halt_state", {halted, S1, S0, ad_oe, bus_oe}, 5'b10001);
    wake = 1'b1;
    tick();
    chk("halt_wake", {halted, cyc_done}, 2'b01);
    wake = 1'b0;

    // Reset while in TW
    start(3'd1, 16'hBEEF, 8'h00); ready = 1'b0;
    tick();
    cyc_req = 1'b0;
    tick();
    tick();
    #2 reset = 1'b1;
    #1;
    chk("rst_tw_ctrl", ctrl_vec(), ResetCtrl);
    chk("rst_tw_bus", {cyc_rdata, a_hi, ad_out}, 24'h0);
    tick();
    #2 reset = 1'b0; ready = 1'b1;
    tick();
    chk("rst_tw_nodone", {cyc_done, ALE}, 2'b00);

`ifdef WAIT_TIMEOUT_EN
    start(3'd1, 16'h0800, 8'h00); ready = 1'b0;
    n = 0; seen = 0;
    for (int i = 0; i < 12 && !seen; i++) begin
      tick();
      cyc_req = 1'b0;
      if (!RDn) n++;
      seen = cyc_done;
    end
    chk("to_rd_low", n, 5);
    chk("to_err", bus_err, 1'b1);
    ready = 1'b1;
    start(3'd1, 16'h0800, 8'h00);
    for (int i = 0; i < 4; i++) begin
      tick();
      cyc_req = 1'b0;
    end
    chk("to_err_sticky", bus_err, 1'b1);
    #2 reset = 1'b1;
    #1 chk("to_err_clear", bus_err, 1'b0);
    tick();
    #2 reset = 1'b0;
`endif

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      tick();
      if ($urandom_range(0, 599) == 0) begin
        #2 reset = 1'b1;
        tick();
        #2 reset = 1'b0;
      end
      cyc_req   = ($urandom_range(0, 3) != 0);
      cyc_type  = 3'($urandom_range(0, 7));
      cyc_long  = 1'($urandom_range(0, 1));
      cyc_addr  = 16'($urandom);
      cyc_wdata = 8'($urandom);
      ad_in     = 8'($urandom);
      ready     = ($urandom_range(0, 9) < 7);
      hold      = ($urandom_range(0, 11) == 0);
      wake      = ($urandom_range(0, 3) == 0);
    end
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
